// File: rtl/pll_clk_divider_sync_if.sv
// Divide-select request and divided-clock status between housekeeping (master)
// and pll_clk_divider_sync (slave).
interface pll_clk_divider_sync_if;
    logic [2:0] sel;
    logic       clk_out;
    logic       tick;
    logic [2:0] n_active;
    logic       switching;

    modport master (output sel, input clk_out, tick, n_active, switching);
    modport slave  (input sel, output clk_out, tick, n_active, switching);
endinterface

// File: rtl/pll_clk_divider_sync.sv
// Glitch-free programmable integer divider of pll_clk with synchronized, debounced select.
// Define CLK_DIV_ODD50_EN to stretch odd divides to 50% duty with a negedge flop.
module pll_clk_divider_sync #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned RESET_DIV     = 1
) (
    input  logic                  pll_clk,
    input  logic                  resetb_async,
    pll_clk_divider_sync_if.slave div_if
);
    localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);
    localparam logic [2:0] ResetDiv  = 3'(RESET_DIV);
    localparam logic       ResetThru = (RESET_DIV < 2);

    function automatic logic [2:0] eff_n(input logic [2:0] v);
        return (v < 3'd2) ? 3'd1 : v;
    endfunction

    logic [2:0] r_sel_s1;
    logic [2:0] r_sel_s2;
    logic [3:0] r_stab_cnt;
    logic [2:0] r_req;
    logic [2:0] r_n_active;
    logic       r_switching;
    logic       r_running;
    logic       r_thru;
    logic       r_r;
    logic       r_tick;
    logic [2:0] r_cnt;

    logic [2:0] w_n;
    logic       w_period_end;
    logic       w_apply;
    logic [2:0] w_n_active_d;
    logic [2:0] w_n_d;
    logic [2:0] w_cnt_d;
    logic       w_r_d;
    logic       w_thru_d;
    logic       w_tick_d;
    logic       w_level;

    assign w_n          = eff_n(r_n_active);
    assign w_period_end = (r_cnt == w_n - 3'd1);
    assign w_apply      = r_running & w_period_end & r_switching;

    // Leaving reset is treated as a period start so the first edge is a full rising edge.
    always_comb begin
        w_n_active_d = r_n_active;
        w_cnt_d      = r_cnt;
        if (!r_running) begin
            w_cnt_d = 3'd0;
        end else if (w_apply) begin
            w_n_active_d = r_req;
            w_cnt_d      = 3'd0;
        end else if (w_period_end) begin
            w_cnt_d = 3'd0;
        end else begin
            w_cnt_d = r_cnt + 3'd1;
        end
        w_n_d    = eff_n(w_n_active_d);
        w_r_d    = (w_cnt_d < (w_n_d >> 1));
        w_thru_d = (w_n_d == 3'd1);
        w_tick_d = (w_cnt_d == 3'd0);
    end

    always_ff @(posedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            r_sel_s1    <= 3'd0;
            r_sel_s2    <= 3'd0;
            r_stab_cnt  <= 4'd0;
            r_req       <= ResetDiv;
            r_switching <= 1'b0;
        end else begin
            r_sel_s1 <= div_if.sel;
            r_sel_s2 <= r_sel_s1;
            // Clear in the same cycle the new value lands in sel_s2.
            if (r_sel_s1 != r_sel_s2) begin
                r_stab_cnt <= 4'd0;
            end else if (r_stab_cnt != StableMax) begin
                r_stab_cnt <= r_stab_cnt + 4'd1;
            end
            if (r_stab_cnt == StableMax) begin
                r_req <= r_sel_s2;
            end
            r_switching <= (r_req != r_n_active);
        end
    end

    always_ff @(posedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            r_running  <= 1'b0;
            r_n_active <= ResetDiv;
            r_cnt      <= 3'd0;
            r_r        <= 1'b0;
            r_thru     <= ResetThru;
            r_tick     <= 1'b0;
        end else begin
            r_running  <= 1'b1;
            r_n_active <= w_n_active_d;
            r_cnt      <= w_cnt_d;
            r_r        <= w_r_d;
            r_thru     <= w_thru_d;
            r_tick     <= w_tick_d;
        end
    end

`ifdef CLK_DIV_ODD50_EN
    localparam logic ResetOdd = (RESET_DIV >= 3) && (RESET_DIV % 2 == 1);

    logic r_odd;
    logic r_r_n;

    always_ff @(posedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            r_odd <= ResetOdd;
        end else begin
            r_odd <= w_n_d[0] & (w_n_d != 3'd1);
        end
    end

    // Half-cycle delayed copy extends the high phase by half a pll_clk period.
    always_ff @(negedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            r_r_n <= 1'b0;
        end else begin
            r_r_n <= r_r;
        end
    end

    assign w_level = r_odd ? (r_r | r_r_n) : r_r;
`else
    assign w_level = r_r;
`endif

    assign div_if.clk_out   = r_running & (r_thru ? pll_clk : w_level);
    assign div_if.tick      = r_tick;
    assign div_if.n_active  = r_n_active;
    assign div_if.switching = r_switching;
endmodule
